// File: rtl/uc_io_if.sv
// Control interface between the uc_io control unit and the datapath.
// The master side is the control unit; the slave side is the datapath / I/O responder.
interface uc_io_if;
    logic [5:0] opcode;
    logic       z;
    logic       ALUoflow;
    logic       io_ack;
    logic       resume;
    logic       s_inc;
    logic       s_inm;
    logic       s_datos;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       pc_en;
    logic       io_rd_req;
    logic       halted;
    logic       io_err;
    logic       oflow_err;

    modport master (
        input  opcode, z, ALUoflow, io_ack, resume,
        output s_inc, s_inm, s_datos, we3, wez, op_alu, pc_en,
               io_rd_req, halted, io_err, oflow_err
    );

    modport slave (
        output opcode, z, ALUoflow, io_ack, resume,
        input  s_inc, s_inm, s_datos, we3, wez, op_alu, pc_en,
               io_rd_req, halted, io_err, oflow_err
    );
endinterface

// File: rtl/uc_io.sv
// Control unit: decodes opcode into datapath controls and stalls the PC for wait-stated I/O reads.
// Non-IN instructions take one cycle; IN stalls until io_ack or TIMEOUT, then HALT waits for resume.
module uc_io #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic     clk,
    input  logic     reset,
    uc_io_if.master  ctl
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_IO_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_io_err;
    logic             r_oflow_err;
    logic             w_set_io_err;
    logic             w_set_oflow;

    always_comb begin
        ctl.s_inc     = 1'b1;
        ctl.s_inm     = 1'b0;
        ctl.s_datos   = 1'b0;
        ctl.we3       = 1'b0;
        ctl.wez       = 1'b0;
        ctl.op_alu    = ctl.opcode[2:0];
        ctl.pc_en     = 1'b1;
        ctl.io_rd_req = 1'b0;
        ctl.halted    = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_set_io_err  = 1'b0;

        case (r_state)
            ST_RUN: begin
                casez (ctl.opcode)
                    6'b000???: begin
                        ctl.we3 = 1'b1;
                        ctl.wez = 1'b1;
                    end
                    6'b001???: begin
                        ctl.we3   = 1'b1;
                        ctl.wez   = 1'b1;
                        ctl.s_inm = 1'b1;
                    end
                    6'b010000: begin
                        ctl.io_rd_req = 1'b1;
                        if (ctl.io_ack) begin
                            ctl.we3     = 1'b1;
                            ctl.s_datos = 1'b1;
                        end else begin
                            ctl.pc_en   = 1'b0;
                            w_state_nxt = ST_IO_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end
                    6'b100000: ctl.s_inc = 1'b0;
                    6'b100001: ctl.s_inc = ~ctl.z;
                    6'b100010: ctl.s_inc = ctl.z;
                    6'b111111: begin
                        ctl.pc_en   = 1'b0;
                        w_state_nxt = ST_HALT;
                    end
                    default: ;
                endcase
            end

            ST_IO_WAIT: begin
                ctl.io_rd_req = 1'b1;
                ctl.pc_en     = 1'b0;
                w_cnt_nxt     = r_cnt + CNT_ONE;
                // A late ack on the final wait cycle still completes the read.
                if (ctl.io_ack) begin
                    ctl.we3     = 1'b1;
                    ctl.s_datos = 1'b1;
                    ctl.pc_en   = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    ctl.io_rd_req = 1'b0;
                    ctl.pc_en     = 1'b1;
                    w_set_io_err  = 1'b1;
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                end
            end

            ST_HALT: begin
                ctl.halted = 1'b1;
                ctl.pc_en  = 1'b0;
                if (ctl.resume) begin
                    ctl.pc_en   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (reset) begin
            ctl.we3       = 1'b0;
            ctl.wez       = 1'b0;
            ctl.pc_en     = 1'b0;
            ctl.io_rd_req = 1'b0;
            ctl.halted    = 1'b0;
        end
    end

    assign w_set_oflow = (r_state == ST_RUN) && ctl.wez && ctl.ALUoflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_io_err    <= 1'b0;
            r_oflow_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_set_io_err) r_io_err    <= 1'b1;
            if (w_set_oflow)  r_oflow_err <= 1'b1;
        end
    end

    assign ctl.io_err    = r_io_err;
    assign ctl.oflow_err = r_oflow_err;

endmodule

// File: tb/tb_uc_io.sv
// Directed bench for uc_io: decode table in RUN plus hand-written I/O wait, timeout, HALT and reset sequences.
module tb_uc_io;
    localparam int TIMEOUT = 16;
    localparam logic [5:0] OP_NOP = 6'b011101;
    localparam logic [5:0] OP_IN  = 6'b010000;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    uc_io_if ctl ();

    uc_io #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {s_inc,s_inm,s_datos,we3,wez,op_alu[2:0],pc_en,io_rd_req,halted}
    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        ofl;
        logic        ack;
        logic        res;
        logic [10:0] exp;
        string       nm;
    } vec_t;

    function automatic logic [10:0] outs();
        return {ctl.s_inc, ctl.s_inm, ctl.s_datos, ctl.we3, ctl.wez, ctl.op_alu,
                ctl.pc_en, ctl.io_rd_req, ctl.halted};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic z, input logic ofl,
                         input logic ack, input logic res);
        ctl.opcode   = op;
        ctl.z        = z;
        ctl.ALUoflow = ofl;
        ctl.io_ack   = ack;
        ctl.resume   = res;
    endtask

    // c=0 is the RUN cycle of IN, c=1..TIMEOUT are IO_WAIT cycles; ack_cyc<0 means never ack.
    task automatic in_seq(input int ack_cyc, output int req_cnt, output int stall_cnt,
                          output logic wrote, output logic bad_to);
        req_cnt = 0; stall_cnt = 0; wrote = 1'b0; bad_to = 1'b0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            @(negedge clk);
            drive(OP_IN, 1'b0, 1'b0, (c == ack_cyc), 1'b0);
            #1;
            if (ctl.io_rd_req) req_cnt++;
            if (!ctl.pc_en) stall_cnt++;
            if (ctl.we3 && ctl.s_datos) wrote = 1'b1;
            if (ctl.pc_en) begin
                if (!ctl.s_inc) bad_to = 1'b1;
                break;
            end
        end
        @(negedge clk);
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    vec_t tbl[10];
    int   rq, st;
    logic wr, bt;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        tbl[0] = '{6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_0_1_1_010_1_0_0, "alu_rr"};
        tbl[1] = '{6'b001011, 1'b0, 1'b0, 1'b0, 1'b0, 11'b1_1_0_1_1_011_1_0_0, "alu_imm"};
        tbl[2] = '{6'b100001, 1'b1, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_001_1_0_0, "jz_z1"};
        tbl[3] = '{6'b100001, 1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_0_0_0_001_1_0_0, "jz_z0"};
        tbl[4] = '{6'b100010, 1'b1, 1'b0, 1'b0, 1'b0, 11'b1_0_0_0_0_010_1_0_0, "jnz_z1"};
        tbl[5] = '{6'b100010, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_010_1_0_0, "jnz_z0"};
        tbl[6] = '{6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0_0_0_0_0_000_1_0_0, "jump"};
        tbl[7] = '{6'b010000, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1_0_1_1_0_000_1_1_0, "in_fast_ack"};
        tbl[8] = '{6'b011101, 1'b0, 1'b0, 1'b0, 1'b0, 11'b1_0_0_0_0_101_1_0_0, "nop"};
        tbl[9] = '{6'b000111, 1'b0, 1'b0, 1'b0, 1'b1, 11'b1_0_0_1_1_111_1_0_0, "resume_in_run"};

        // Reset: controls forced low even with an ALU opcode present
        reset = 1'b1;
        drive(6'b000010, 1'b0, 1'b1, 1'b1, 1'b1);
        #12;
        chk("rst_ctl", {11'd0, ctl.we3, ctl.wez, ctl.pc_en, ctl.io_rd_req, ctl.halted}, 16'd0);
        chk("rst_flags", {14'd0, ctl.io_err, ctl.oflow_err}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].z, tbl[i].ofl, tbl[i].ack, tbl[i].res);
            #1;
            chk(tbl[i].nm, {5'd0, outs()}, {5'd0, tbl[i].exp});
        end
        @(negedge clk);
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("resume_run_no_halt", {15'd0, ctl.halted}, 16'd0);
        chk("oflow_clear", {15'd0, ctl.oflow_err}, 16'd0);

        // IN with ack on the third wait cycle
        in_seq(3, rq, st, wr, bt);
        chk("in_ack3_req", 16'(rq), 16'd4);
        chk("in_ack3_stall", 16'(st), 16'd3);
        chk("in_ack3_write", {15'd0, wr}, 16'd1);
        chk("in_ack3_back_run", {14'd0, ctl.pc_en, ctl.io_rd_req}, 16'b10);

        // Ack on the final allowed wait cycle wins over timeout
        in_seq(TIMEOUT, rq, st, wr, bt);
        chk("in_ack16_req", 16'(rq), 16'd17);
        chk("in_ack16_stall", 16'(st), 16'd16);
        chk("in_ack16_write", {15'd0, wr}, 16'd1);
        chk("in_ack16_ioerr", {15'd0, ctl.io_err}, 16'd0);

        // No ack: timeout
        in_seq(-1, rq, st, wr, bt);
        chk("to_req", 16'(rq), 16'd16);
        chk("to_stall", 16'(st), 16'd16);
        chk("to_nowrite", {14'd0, wr, bt}, 16'd0);
        chk("to_ioerr", {15'd0, ctl.io_err}, 16'd1);
        in_seq(-1, rq, st, wr, bt);
        chk("to2_ioerr_sticky", {15'd0, ctl.io_err}, 16'd1);

        // HALT and resume
        @(negedge clk);
        drive(6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("halt_issue", {13'd0, ctl.pc_en, ctl.halted, ctl.we3}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("halt_hold", {12'd0, ctl.halted, ctl.pc_en, ctl.we3, ctl.io_rd_req}, 16'b1000);
        end
        @(negedge clk);
        ctl.resume = 1'b1;
        #1;
        chk("resume_step", {13'd0, ctl.halted, ctl.pc_en, ctl.s_inc}, 16'b111);
        @(negedge clk);
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("after_resume", {14'd0, ctl.halted, ctl.pc_en}, 16'b01);

        // Async reset mid-IO_WAIT with counter at 7
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            drive(OP_IN, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        #1;
        chk("wait_before_rst", {14'd0, ctl.io_rd_req, ctl.pc_en}, 16'b10);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_req", {14'd0, ctl.io_rd_req, ctl.io_err}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_run", {13'd0, ctl.pc_en, ctl.halted, ctl.oflow_err}, 16'b100);
        in_seq(-1, rq, st, wr, bt);
        chk("post_rst_cnt0", 16'(st), 16'd16);

        // Overflow on a non flag-writing op is ignored; on ALU immediate it sticks
        @(negedge clk);
        drive(6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(6'b001011, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("oflow_jump_ignored", {15'd0, ctl.oflow_err}, 16'd0);
        @(negedge clk);
        drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("oflow_set", {15'd0, ctl.oflow_err}, 16'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("oflow_sticky", {15'd0, ctl.oflow_err}, 16'd1);
        reset = 1'b1;
        #2;
        chk("oflow_rst_clear", {14'd0, ctl.oflow_err, ctl.io_err}, 16'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
